// File: rtl/uart_tx_frame.sv
// uart_tx_frame: asynchronous UART transmitter.
// Each frame is a start bit, DATA_WIDTH data bits sent LSB first, an optional
// parity bit and one stop bit. Every bit lasts `prescale` system clocks.
// TX_OUT and busy are registered and track the state entered at each edge.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int              BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [2:0]            r_state;
    logic [5:0]            r_cyc;
    logic [5:0]            r_pre_m1;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_par_en;
    logic                  r_tx;
    logic                  r_busy;

    logic [5:0]            w_pre_m1;
    logic                  w_bit_end;

    // Decode prescale into a terminal count; unsupported values fall back to 8.
    always_comb begin
        w_pre_m1 = 6'd7;
        case (prescale)
            6'd16:   w_pre_m1 = 6'd15;
            6'd32:   w_pre_m1 = 6'd31;
            default: w_pre_m1 = 6'd7;
        endcase
    end

    assign w_bit_end = (r_cyc == r_pre_m1);

    // Frame sequencer: accepts a request when idle, then walks through the bits.
    // The shift register is advanced when each data bit is launched, so bit 0
    // of the register always holds the next data bit to send.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cyc    <= '0;
            r_pre_m1 <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_par_en <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_cyc  <= '0;
                    if (Data_Valid) begin
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_shift  <= P_DATA;
                        r_par    <= (^P_DATA) ^ PAR_TYP;
                        r_par_en <= PAR_EN;
                        r_pre_m1 <= w_pre_m1;
                        r_bit    <= '0;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_cyc <= r_cyc + 6'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cyc <= '0;
                        if (r_bit == LAST_BIT) begin
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 6'd1;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + 6'd1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_cyc   <= '0;
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cyc <= r_cyc + 6'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: table of directed frames with hand-computed
// line patterns, plus hand-written back-to-back and reset-mid-frame sequences.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // exp bit n = line level during bit window n (n = 0 is the start bit)
    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [5:0]  pre;
        int          bitlen;
        int          busy_exp;
        logic [10:0] exp;
        logic        mid_dv;
        logic        mid_chg;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launch one frame with a single-cycle request and check every bit window,
    // the busy duration and the return to idle.
    task automatic run_frame(input string tag, input vec_t v);
        int  nbits;
        int  busy_cnt;
        int  act_val;
        bit  mism;
        logic exp_bit;
        P_DATA     = v.data;
        PAR_EN     = v.pe;
        PAR_TYP    = v.pt;
        prescale   = v.pre;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        nbits    = v.busy_exp / v.bitlen;
        busy_cnt = 0;
        for (int n = 0; n < nbits; n++) begin
            exp_bit = v.exp[n];
            mism    = 1'b0;
            act_val = 0;
            for (int j = 0; j < v.bitlen; j++) begin
                int c;
                c = n * v.bitlen + j;
                if (v.mid_dv && c == 20) begin
                    P_DATA     = 8'hFF;
                    Data_Valid = 1'b1;
                end
                if (v.mid_dv && c == 21) begin
                    Data_Valid = 1'b0;
                end
                if (v.mid_chg && c == 30) begin
                    P_DATA   = ~v.data;
                    PAR_EN   = ~v.pe;
                    PAR_TYP  = ~v.pt;
                    prescale = 6'd32;
                end
                if (busy === 1'b1) busy_cnt++;
                if (!mism) begin
                    act_val = int'(TX_OUT);
                    if (TX_OUT !== exp_bit) mism = 1'b1;
                end
                tick();
            end
            chk($sformatf("%s bit%0d", tag, n), act_val, int'(exp_bit));
        end
        chk($sformatf("%s tx_after", tag), int'(TX_OUT), 1);
        chk($sformatf("%s busy_fall", tag), int'(busy), 0);
        for (int j = 0; j < 3; j++) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
        chk($sformatf("%s busy_cycles", tag), busy_cnt, v.busy_exp);
    endtask

    initial begin
        int rise, fall, prev, b80, b81, drained;

        //           data   pe    pt    pre    bl  busy  exp      mid_dv mid_chg
        vt[0] = '{8'hA5, 1'b1, 1'b0, 6'd8,  8,  88,  11'h54A, 1'b0, 1'b0};
        vt[1] = '{8'hA5, 1'b1, 1'b1, 6'd8,  8,  88,  11'h74A, 1'b0, 1'b0};
        vt[2] = '{8'h3C, 1'b0, 1'b0, 6'd16, 16, 160, 11'h278, 1'b0, 1'b0};
        vt[3] = '{8'h0F, 1'b1, 1'b0, 6'd12, 8,  88,  11'h41E, 1'b0, 1'b1};
        vt[4] = '{8'h01, 1'b0, 1'b0, 6'd32, 32, 320, 11'h202, 1'b1, 1'b0};
        vt[5] = '{8'h00, 1'b1, 1'b1, 6'd8,  8,  88,  11'h600, 1'b0, 1'b0};

        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;
        tick();
        tick();
        tick();
        chk("reset tx", int'(TX_OUT), 1);
        chk("reset busy", int'(busy), 0);
        RST = 1'b0;
        tick();
        chk("idle tx", int'(TX_OUT), 1);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("v%0d", i), vt[i]);
        end

        // Back-to-back with Data_Valid held: 0x55, prescale 8, no parity.
        // Stop bit starts at cycle 72, busy drops at 80, next start at 81.
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;
        Data_Valid = 1'b1;
        tick();
        prev = int'(TX_OUT);
        rise = -1;
        fall = -1;
        b80  = -1;
        b81  = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (c == 80) b80 = int'(busy);
            if (c == 81) b81 = int'(busy);
            if (TX_OUT === 1'b1 && prev == 0) rise = c;
            if (TX_OUT === 1'b0 && prev == 1 && c > 70) begin
                fall = c;
                break;
            end
            prev = int'(TX_OUT);
        end
        Data_Valid = 1'b0;
        chk("b2b stop_start", rise, 72);
        chk("b2b next_start", fall, 81);
        chk("b2b gap", fall - rise, 9);
        chk("b2b busy_at_done", b80, 0);
        chk("b2b busy_reaccept", b81, 1);
        drained = 0;
        for (int c = 0; c < 500; c++) begin
            if (busy === 1'b0) begin
                drained = 1;
                break;
            end
            tick();
        end
        chk("b2b drained", drained, 1);
        tick();

        // Reset during data bit 3 of 0xA5 (bit window 4, cycles 32..39).
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int c = 0; c < 34; c++) tick();
        chk("rst data_bit3", int'(TX_OUT), 0);
        chk("rst busy_before", int'(busy), 1);
        RST = 1'b1;
        tick();
        chk("rst mid tx", int'(TX_OUT), 1);
        chk("rst mid busy", int'(busy), 0);
        RST = 1'b0;
        tick();
        tick();
        chk("rst idle tx", int'(TX_OUT), 1);
        chk("rst idle busy", int'(busy), 0);
        run_frame("post_rst", '{8'h81, 1'b1, 1'b0, 6'd8, 8, 88, 11'h502, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
